// File: rtl/sparse_mul_param.sv
// sparse_mul_param
//   Sparse polynomial multiplier r = a*s over Z_Q[x]/(x^N+1) (or x^N-1),
//   where a is dense (coefficients in [0,Q)) and s is sparse ternary with
//   H nonzero coefficients given as signed positions. CORE_NUM positions
//   are consumed per pass over all N result coefficients. The result is
//   either cleared or accumulated (acc_mode, latched with start).
//
//   Build option: define SPM_NEGACYCLIC_EN for reduction mod x^N+1, where a
//   wrapped term flips sign. Leave it undefined for cyclic reduction mod x^N-1.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, acc_mode     start pulse (accepted in IDLE), 0=clear / 1=accumulate
//   busy, done          busy while computing, one-cycle done pulse
//   mem_poly_*          write port of the (replicated) dense polynomial RAM
//   mem_pos_*           write port of the position RAM, CORE_NUM slots per word
//   sw_mem_res_*        software read port of the result RAM
//   mem_res_dout        result read data, one-cycle latency
module sparse_mul_param #(
    parameter int Q           = 251,
    parameter int N           = 512,
    parameter int H           = 256,
    parameter int CORE_NUM    = 2,
    parameter int COEFF_WIDTH = 8,
    parameter int POS_WIDTH   = $clog2(N),
    parameter int POS_DEPTH   = (H + CORE_NUM - 1) / CORE_NUM,
    parameter int POS_AW      = (POS_DEPTH > 1) ? $clog2(POS_DEPTH) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              acc_mode,
    output logic                              busy,
    output logic                              done,
    input  logic                              mem_poly_wren,
    input  logic [POS_WIDTH-1:0]              mem_poly_wr_addr,
    input  logic [COEFF_WIDTH-1:0]            mem_poly_din,
    input  logic                              mem_pos_wren,
    input  logic [POS_AW-1:0]                 mem_pos_wr_addr,
    input  logic [(POS_WIDTH+1)*CORE_NUM-1:0] mem_pos_din,
    input  logic                              sw_mem_res_rden,
    input  logic [POS_WIDTH-1:0]              sw_mem_res_rd_addr,
    output logic [COEFF_WIDTH-1:0]            mem_res_dout
);
    localparam int SLOT_W = POS_WIDTH + 1;
    localparam int WORD_W = SLOT_W * CORE_NUM;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    // Modular add of two values already in [0,Q).
    function automatic logic [COEFF_WIDTH-1:0] mod_add(input logic [COEFF_WIDTH-1:0] x,
                                                       input logic [COEFF_WIDTH-1:0] y);
        logic [COEFF_WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= (COEFF_WIDTH+1)'(Q))
            s = s - (COEFF_WIDTH+1)'(Q);
        return s[COEFF_WIDTH-1:0];
    endfunction

    // Modular negation; zero stays zero so the result remains in [0,Q).
    function automatic logic [COEFF_WIDTH-1:0] mod_neg(input logic [COEFF_WIDTH-1:0] x);
        return (x == '0) ? '0 : COEFF_WIDTH'(Q) - x;
    endfunction

    state_t               state_q;
    logic [POS_AW-1:0]    w_q;
    logic [POS_WIDTH-1:0] k_q;
    logic [1:0]           drain_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 clear_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        w_q     <= '0;
                        clear_q <= ~acc_mode;
                    end
                end
                S_LOAD: begin
                    state_q <= S_RUN;
                    k_q     <= '0;
                end
                S_RUN: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == POS_WIDTH'(N - 1)) begin
                        if (w_q == POS_AW'(POS_DEPTH - 1)) begin
                            state_q <= S_DRAIN;
                            drain_q <= '0;
                        end else begin
                            state_q <= S_LOAD;
                            w_q     <= w_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == 2'd2) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // Position RAM: the word for pass w is read continuously so it is
    // registered at the end of LOAD and stays stable through RUN.
    logic [WORD_W-1:0] pos_mem [POS_DEPTH];
    logic [WORD_W-1:0] pos_q;

    always_ff @(posedge clk) begin
        if (mem_pos_wren && !busy_q)
            pos_mem[mem_pos_wr_addr] <= mem_pos_din;
        pos_q <= pos_mem[w_q];
    end

    // ---- stage 0: per-core poly index, sign and slot enable ----
    logic [POS_WIDTH-1:0] idx_d [CORE_NUM];
    logic [CORE_NUM-1:0]  neg_d;
    logic [CORE_NUM-1:0]  en_d;

    always_comb begin
        logic [SLOT_W-1:0] slot;
        slot  = '0;
        neg_d = '0;
        en_d  = '0;
        for (int c = 0; c < CORE_NUM; c++) begin
            slot     = pos_q[(c+1)*SLOT_W-1 -: SLOT_W];
            // N is a power of two, so truncation gives (k-p) mod N.
            idx_d[c] = k_q - slot[POS_WIDTH-1:0];
`ifdef SPM_NEGACYCLIC_EN
            neg_d[c] = slot[POS_WIDTH] ^ (k_q < slot[POS_WIDTH-1:0]);
`else
            neg_d[c] = slot[POS_WIDTH];
`endif
            // Padding slots of the last word contribute nothing.
            en_d[c]  = (int'(w_q) * CORE_NUM + c) < H;
        end
    end

    // Replicated poly RAM: every copy is written together, each core reads its own.
    logic [COEFF_WIDTH-1:0] poly_p1 [CORE_NUM];

    for (genvar gc = 0; gc < CORE_NUM; gc++) begin : g_core
        logic [COEFF_WIDTH-1:0] poly_mem [N];
        logic [COEFF_WIDTH-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (mem_poly_wren && !busy_q)
                poly_mem[mem_poly_wr_addr] <= mem_poly_din;
            rd_q <= poly_mem[idx_d[gc]];
        end
        assign poly_p1[gc] = rd_q;
    end

    // Result RAM, single read port shared by the datapath and software.
    logic [COEFF_WIDTH-1:0] res_mem [N];
    logic [POS_WIDTH-1:0]   res_raddr;
    logic [COEFF_WIDTH-1:0] res_old_p1;
    logic [COEFF_WIDTH-1:0] sum_p2;
    logic [POS_WIDTH-1:0]   k_p2;
    logic                   vld_p2;

    assign res_raddr = busy_q ? k_q : sw_mem_res_rd_addr;

    always_ff @(posedge clk) begin
        res_old_p1 <= res_mem[res_raddr];
        if (vld_p2)
            res_mem[k_p2] <= sum_p2;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mem_res_dout <= '0;
        else if (sw_mem_res_rden)
            mem_res_dout <= res_mem[res_raddr];
    end

    // ---- stage 1: RAM data returns, form the modular sum ----
    logic                   vld_p1;
    logic [POS_WIDTH-1:0]   k_p1;
    logic [CORE_NUM-1:0]    neg_p1;
    logic [CORE_NUM-1:0]    en_p1;
    logic                   first_p1;
    logic [COEFF_WIDTH-1:0] sum_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= (state_q == S_RUN);
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        k_p1     <= k_q;
        neg_p1   <= neg_d;
        en_p1    <= en_d;
        first_p1 <= clear_q && (w_q == '0);
    end

    always_comb begin
        logic [COEFF_WIDTH-1:0] term;
        term  = '0;
        sum_d = first_p1 ? '0 : res_old_p1;
        for (int c = 0; c < CORE_NUM; c++) begin
            term = neg_p1[c] ? mod_neg(poly_p1[c]) : poly_p1[c];
            if (!en_p1[c])
                term = '0;
            sum_d = mod_add(sum_d, term);
        end
    end

    // ---- stage 2: register reduced sum; stage 3 writes it back ----
    always_ff @(posedge clk) begin
        sum_p2 <= sum_d;
        k_p2   <= k_p1;
    end

endmodule

// File: tb/tb_sparse_mul_param.sv
module tb_sparse_mul_param;
    localparam int Q  = 251;
    localparam int N  = 512;
    localparam int LAT_1    = 517;
    localparam int LAT_FULL = 65668;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_mode;
    logic        poly_wren;
    logic [8:0]  poly_addr;
    logic [7:0]  poly_din;
    logic [19:0] pos_din;
    logic        rden;
    logic [8:0]  rd_addr;

    logic        start_f, start_s;
    logic        pos_wren_f, pos_wren_s;
    logic [6:0]  pos_addr_f;
    logic [0:0]  pos_addr_s;
    logic        busy_f, busy_s, done_f, done_s;
    logic [7:0]  dout_f, dout_s;

    int checks = 0;
    int errors = 0;

    int a_m   [N];
    int mp    [256];
    bit ms    [256];
    int exp_r [N];

    always #5 clk = ~clk;

    // Full-size instance (defaults) and a single-position instance.
    sparse_mul_param #(.Q(Q), .N(N), .H(256), .CORE_NUM(2), .COEFF_WIDTH(8)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .acc_mode(acc_mode),
        .busy(busy_f), .done(done_f),
        .mem_poly_wren(poly_wren), .mem_poly_wr_addr(poly_addr), .mem_poly_din(poly_din),
        .mem_pos_wren(pos_wren_f), .mem_pos_wr_addr(pos_addr_f), .mem_pos_din(pos_din),
        .sw_mem_res_rden(rden), .sw_mem_res_rd_addr(rd_addr), .mem_res_dout(dout_f)
    );

    sparse_mul_param #(.Q(Q), .N(N), .H(1), .CORE_NUM(2), .COEFF_WIDTH(8)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .acc_mode(acc_mode),
        .busy(busy_s), .done(done_s),
        .mem_poly_wren(poly_wren), .mem_poly_wr_addr(poly_addr), .mem_poly_din(poly_din),
        .mem_pos_wren(pos_wren_s), .mem_pos_wr_addr(pos_addr_s), .mem_pos_din(pos_din),
        .sw_mem_res_rden(rden), .sw_mem_res_rd_addr(rd_addr), .mem_res_dout(dout_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift every a[j] to j+p, fold past N with optional sign flip.
    task automatic golden(input int nh, input bit acc);
        int t, term;
        bit flip;
        if (!acc)
            for (int k = 0; k < N; k++) exp_r[k] = 0;
        for (int i = 0; i < nh; i++) begin
            for (int j = 0; j < N; j++) begin
                t = j + mp[i];
                flip = 1'b0;
                if (t >= N) begin
                    t = t - N;
`ifdef SPM_NEGACYCLIC_EN
                    flip = 1'b1;
`endif
                end
                term = a_m[j];
                if (ms[i] ^ flip) term = (Q - term) % Q;
                exp_r[t] = (exp_r[t] + term) % Q;
            end
        end
    endtask

    task automatic write_poly();
        for (int i = 0; i < N; i++) begin
            a_m[i]    = i % Q;
            poly_wren = 1'b1;
            poly_addr = 9'(i);
            poly_din  = 8'(i % Q);
            tick();
        end
        poly_wren = 1'b0;
    endtask

    // Slot 0 holds the real position; slot 1 is junk beyond H and must be ignored.
    task automatic write_pos_s(input int p, input bit sg);
        mp[0]      = p;
        ms[0]      = sg;
        pos_din    = {10'h3A5, sg, 9'(p)};
        pos_addr_s = 1'b0;
        pos_wren_s = 1'b1;
        tick();
        pos_wren_s = 1'b0;
    endtask

    task automatic write_pos_f();
        for (int w = 0; w < 128; w++) begin
            mp[2*w]   = 2*w + 1;
            mp[2*w+1] = 2*w + 2;
            ms[2*w]   = 1'b0;
            ms[2*w+1] = 1'b0;
            pos_din    = {1'b0, 9'(2*w + 2), 1'b0, 9'(2*w + 1)};
            pos_addr_f = 7'(w);
            pos_wren_f = 1'b1;
            tick();
        end
        pos_wren_f = 1'b0;
    endtask

    // Start a run, inject a stray start while busy, and time the done pulse.
    task automatic run(input int sel, input logic acc, input int exp_lat, input string name);
        int   cnt;
        logic seen, dn, bz;
        acc_mode = acc;
        if (sel == 0) start_f = 1'b1; else start_s = 1'b1;
        tick();
        start_f = 1'b0;
        start_s = 1'b0;
        cnt = 1;
        bz = (sel == 0) ? busy_f : busy_s;
        checks++;
        if (bz !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, bz);
        end
        seen = 1'b0;
        while (!seen && cnt < 70000) begin
            dn = (sel == 0) ? done_f : done_s;
            if (dn === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (cnt == 5) begin
                    if (sel == 0) start_f = 1'b1; else start_s = 1'b1;
                end
                tick();
                start_f = 1'b0;
                start_s = 1'b0;
                cnt++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: got no done after %0d cycles want %0d", name, cnt, exp_lat);
        end else if (cnt != exp_lat) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", name, cnt, exp_lat);
        end
        if (seen) begin
            bz = (sel == 0) ? busy_f : busy_s;
            checks++;
            if (bz !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_done: got %b want 0", name, bz);
            end
            tick();
            dn = (sel == 0) ? done_f : done_s;
            checks++;
            if (dn !== 1'b0) begin
                errors++;
                $display("FAIL %s done_width: got %b want 0", name, dn);
            end
        end
    endtask

    // Scoreboard: expected value queued with each read address, popped on return.
    task automatic read_all(input int sel, input string name);
        int   q[$];
        int   e;
        logic [7:0] d;
        rden = 1'b1;
        for (int a = 0; a < N; a++) begin
            rd_addr = 9'(a);
            q.push_back(exp_r[a]);
            tick();
            e = q.pop_front();
            d = (sel == 0) ? dout_f : dout_s;
            checks++;
            if (d !== 8'(e)) begin
                errors++;
                $display("FAIL %s res[%0d]: got %0d want %0d", name, a, d, e);
            end
        end
        rden    = 1'b0;
        rd_addr = 9'd0;
        q.push_back(exp_r[N-1]);
        tick();
        e = q.pop_front();
        d = (sel == 0) ? dout_f : dout_s;
        checks++;
        if (d !== 8'(e)) begin
            errors++;
            $display("FAIL %s dout_hold: got %0d want %0d", name, d, e);
        end
    endtask

    task automatic read_one(input int sel, input int addr, input int want, input string name);
        int   q[$];
        int   e;
        logic [7:0] d;
        rden    = 1'b1;
        rd_addr = 9'(addr);
        q.push_back(want);
        tick();
        rden = 1'b0;
        e = q.pop_front();
        d = (sel == 0) ? dout_f : dout_s;
        checks++;
        if (d !== 8'(e)) begin
            errors++;
            $display("FAIL %s res[%0d]: got %0d want %0d", name, addr, d, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks += 6;
        if (busy_f !== 1'b0) begin errors++; $display("FAIL reset busy_f: got %b want 0", busy_f); end
        if (done_f !== 1'b0) begin errors++; $display("FAIL reset done_f: got %b want 0", done_f); end
        if (dout_f !== 8'd0) begin errors++; $display("FAIL reset dout_f: got %0d want 0", dout_f); end
        if (busy_s !== 1'b0) begin errors++; $display("FAIL reset busy_s: got %b want 0", busy_s); end
        if (done_s !== 1'b0) begin errors++; $display("FAIL reset done_s: got %b want 0", done_s); end
        if (dout_s !== 8'd0) begin errors++; $display("FAIL reset dout_s: got %0d want 0", dout_s); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        write_pos_s(0, 1'b0);
        run(1, 1'b0, LAT_1, "identity");
        golden(1, 1'b0);
        read_all(1, "identity");
        read_one(1, 300, 49, "identity");
    endtask

    task automatic test_shift();
        write_pos_s(1, 1'b0);
        run(1, 1'b0, LAT_1, "shift");
        golden(1, 1'b0);
        read_all(1, "shift");
`ifdef SPM_NEGACYCLIC_EN
        read_one(1, 0, 242, "shift");
`else
        read_one(1, 0, 9, "shift");
`endif
        read_one(1, 1, 0, "shift");
    endtask

    task automatic test_negative();
        write_pos_s(0, 1'b1);
        run(1, 1'b0, LAT_1, "negative");
        golden(1, 1'b0);
        read_all(1, "negative");
        read_one(1, 0, 0, "negative");
        read_one(1, 5, 246, "negative");
    endtask

    task automatic test_accumulate();
        write_pos_s(0, 1'b0);
        run(1, 1'b0, LAT_1, "acc_first");
        golden(1, 1'b0);
        run(1, 1'b1, LAT_1, "acc_second");
        golden(1, 1'b1);
        read_one(1, 200, 149, "accumulate");
        read_all(1, "accumulate");
    endtask

    task automatic test_reset_midrun();
        int   cnt;
        logic bad;
        acc_mode = 1'b0;
        start_f  = 1'b1;
        tick();
        start_f = 1'b0;
        cnt = 1;
        while (cnt < 1000) begin
            tick();
            cnt++;
        end
        rst = 1'b1;
        tick();
        checks += 2;
        if (busy_f !== 1'b0) begin errors++; $display("FAIL midrun_reset busy: got %b want 0", busy_f); end
        if (done_f !== 1'b0) begin errors++; $display("FAIL midrun_reset done: got %b want 0", done_f); end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done_f !== 1'b0 || busy_f !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset quiet: got activity %b want 0", bad);
        end
    endtask

    task automatic test_full_load();
        run(0, 1'b0, LAT_FULL, "full");
        golden(256, 1'b0);
        read_all(0, "full");
    endtask

    initial begin
        rst        = 1'b1;
        acc_mode   = 1'b0;
        poly_wren  = 1'b0;
        poly_addr  = '0;
        poly_din   = '0;
        pos_din    = '0;
        rden       = 1'b0;
        rd_addr    = '0;
        start_f    = 1'b0;
        start_s    = 1'b0;
        pos_wren_f = 1'b0;
        pos_wren_s = 1'b0;
        pos_addr_f = '0;
        pos_addr_s = '0;

        test_reset();
        write_poly();
        test_identity();
        test_shift();
        test_negative();
        test_accumulate();
        write_pos_f();
        test_reset_midrun();
        test_full_load();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
